// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   hz_state_e : FSM state encoding of hazard_ctrl
//   REG_ZERO   : architectural register $0, which never creates a dependency
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE     = 2'b00,
        HZ_BR_HOLD  = 2'b01,
        HZ_MDU_WAIT = 2'b10
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_match.sv
// hz_match: combinational source-operand vs destination-register comparator.
//   rs, rt         : source register fields of the instruction in ID
//   use_rs, use_rt : the ID instruction actually reads that operand
//   rd             : destination register of an older instruction
//   hit_rs, hit_rt : operand depends on rd (never true for $0)
module hz_match
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] rd,
    output logic       hit_rs,
    output logic       hit_rt
);

    logic rd_live;

    assign rd_live = (rd != REG_ZERO);
    assign hit_rs  = use_rs && (rs == rd) && rd_live;
    assign hit_rt  = use_rt && (rt == rd) && rd_live;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the 5-stage pipeline.
// Covers the hazards forwarding cannot: load-use into EXE, a branch/jr in ID
// reading a load result still in EXE or MEM, and an MDU instruction in ID
// while the multiplier/divider is busy.
//   clk, rstn         : clock, asynchronous active-low reset
//   IFID_*, ID_*      : operand fields and decode flags of the ID instruction
//   br_taken          : branch/jump in ID resolved taken
//   IDEXE_*, EXEMEM_* : destination / load info of the EXE and MEM instructions
//   mdu_busy          : multiplier/divider busy
//   PC_Wr, IFID_Wr    : pipeline front-end write enables
//   IFID_flush        : squash the wrong-path fetch
//   IDEXE_flush       : insert a bubble into EXE
//   stall             : any stall cause active this cycle
//   stall_cnt         : saturating count of stalled cycles
//   mdu_err           : sticky MDU watchdog error
//   dbg_state         : current FSM state
// Handshake: none; every control output is combinational from the current
// state and inputs, so it acts in the same cycle the hazard is seen.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             ID_branch,
    input  logic             ID_mdu,
    input  logic             br_taken,
    input  logic [4:0]       IDEXE_rd,
    input  logic             IDEXE_RFWr,
    input  logic             IDEXE_DMRd,
    input  logic [4:0]       EXEMEM_rd,
    input  logic             EXEMEM_DMRd,
    input  logic             mdu_busy,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IFID_flush,
    output logic             IDEXE_flush,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mdu_err,
    output hz_state_e        dbg_state
);

    localparam int WDOG_W = $clog2(MDU_TIMEOUT + 1);

    hz_state_e         state, state_nxt;
    logic [WDOG_W-1:0] wdog;
    logic              stall_raw;
    logic              wdog_expire;

    logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
    logic hit_exe, hit_mem;
    logic mdu_h, br_ex, br_mem, lu_h;

    hz_match u_match_exe (
        .rs     (IFID_rs),
        .rt     (IFID_rt),
        .use_rs (ID_use_rs),
        .use_rt (ID_use_rt),
        .rd     (IDEXE_rd),
        .hit_rs (exe_hit_rs),
        .hit_rt (exe_hit_rt)
    );

    hz_match u_match_mem (
        .rs     (IFID_rs),
        .rt     (IFID_rt),
        .use_rs (ID_use_rs),
        .use_rt (ID_use_rt),
        .rd     (EXEMEM_rd),
        .hit_rs (mem_hit_rs),
        .hit_rt (mem_hit_rt)
    );

    assign hit_exe = exe_hit_rs || exe_hit_rt;
    assign hit_mem = mem_hit_rs || mem_hit_rt;

    assign mdu_h  = ID_mdu && mdu_busy;
    assign lu_h   = IDEXE_DMRd && IDEXE_RFWr && hit_exe;
    assign br_ex  = ID_branch && lu_h;
    assign br_mem = ID_branch && EXEMEM_DMRd && hit_mem;

    always_comb begin
        state_nxt   = state;
        stall_raw   = 1'b0;
        wdog_expire = 1'b0;
        case (state)
            HZ_IDLE: begin
                stall_raw = mdu_h || br_ex || br_mem || lu_h;
                if (mdu_h) begin
                    state_nxt = HZ_MDU_WAIT;
                end else if (br_ex) begin
                    state_nxt = HZ_BR_HOLD;
                end
            end
            HZ_BR_HOLD: begin
                // Second cycle of the load-in-EXE branch stall.
                stall_raw = 1'b1;
                state_nxt = HZ_IDLE;
            end
            HZ_MDU_WAIT: begin
                if (!mdu_busy) begin
                    state_nxt = HZ_IDLE;
                end else if (wdog == WDOG_W'(MDU_TIMEOUT)) begin
                    // Give up on the MDU and let the instruction go.
                    wdog_expire = 1'b1;
                    state_nxt   = HZ_IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_nxt = HZ_IDLE;
            end
        endcase
    end

    // Held in reset the pipeline must run free regardless of hazard inputs.
    assign stall       = stall_raw && rstn;
    assign PC_Wr       = !stall;
    assign IFID_Wr     = !stall;
    assign IDEXE_flush = stall;
    assign IFID_flush  = !stall && br_taken;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= HZ_IDLE;
            wdog      <= '0;
            stall_cnt <= '0;
            mdu_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // The detecting IDLE cycle is the first MDU stall cycle.
            if (state == HZ_IDLE && mdu_h) begin
                wdog <= WDOG_W'(1);
            end else if (state == HZ_MDU_WAIT && mdu_busy && !wdog_expire) begin
                wdog <= wdog + WDOG_W'(1);
            end
            if (wdog_expire) begin
                mdu_err <= 1'b1;
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] IFID_rs, IFID_rt, IDEXE_rd, EXEMEM_rd;
    logic ID_use_rs, ID_use_rt, ID_branch, ID_mdu, br_taken;
    logic IDEXE_RFWr, IDEXE_DMRd, EXEMEM_DMRd, mdu_busy;

    // dut_a: default parameters; dut_b: short watchdog, narrow counter
    logic a_pc, a_ifid_wr, a_ifid_fl, a_idexe_fl, a_stall, a_err;
    logic b_pc, b_ifid_wr, b_ifid_fl, b_idexe_fl, b_stall, b_err;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;
    hz_state_e   a_st, b_st;
    logic [4:0]  ctl_a, ctl_b;
    assign ctl_a = {a_pc, a_ifid_wr, a_ifid_fl, a_idexe_fl, a_stall};
    assign ctl_b = {b_pc, b_ifid_wr, b_ifid_fl, b_idexe_fl, b_stall};

    localparam logic [4:0] CTL_STALL = 5'b00011;
    localparam logic [4:0] CTL_RUN   = 5'b11000;
    localparam logic [4:0] CTL_TAKEN = 5'b11100;

    hazard_ctrl dut_a (
        .clk(clk), .rstn(rstn), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_branch(ID_branch),
        .ID_mdu(ID_mdu), .br_taken(br_taken), .IDEXE_rd(IDEXE_rd),
        .IDEXE_RFWr(IDEXE_RFWr), .IDEXE_DMRd(IDEXE_DMRd), .EXEMEM_rd(EXEMEM_rd),
        .EXEMEM_DMRd(EXEMEM_DMRd), .mdu_busy(mdu_busy),
        .PC_Wr(a_pc), .IFID_Wr(a_ifid_wr), .IFID_flush(a_ifid_fl),
        .IDEXE_flush(a_idexe_fl), .stall(a_stall), .stall_cnt(a_cnt),
        .mdu_err(a_err), .dbg_state(a_st)
    );

    hazard_ctrl #(.MDU_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rstn(rstn), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_branch(ID_branch),
        .ID_mdu(ID_mdu), .br_taken(br_taken), .IDEXE_rd(IDEXE_rd),
        .IDEXE_RFWr(IDEXE_RFWr), .IDEXE_DMRd(IDEXE_DMRd), .EXEMEM_rd(EXEMEM_rd),
        .EXEMEM_DMRd(EXEMEM_DMRd), .mdu_busy(mdu_busy),
        .PC_Wr(b_pc), .IFID_Wr(b_ifid_wr), .IFID_flush(b_ifid_fl),
        .IDEXE_flush(b_idexe_fl), .stall(b_stall), .stall_cnt(b_cnt),
        .mdu_err(b_err), .dbg_state(b_st)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        IFID_rs = 0; IFID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
        ID_branch = 0; ID_mdu = 0; br_taken = 0;
        IDEXE_rd = 0; IDEXE_RFWr = 0; IDEXE_DMRd = 0;
        EXEMEM_rd = 0; EXEMEM_DMRd = 0; mdu_busy = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Per instance: remaining extra branch stalls, MDU episode flag and the
    // number of stalled cycles spent on it so far, counter and error.
    int     tmo[2]  = '{64, 4};
    longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
    int     m_br[2];
    bit     m_mdu[2];
    int     m_ms[2];
    longint m_cnt[2];
    bit     m_err[2];
    bit     e_stall[2];
    bit     e_to[2];

    function automatic bit dep(input logic [4:0] rd);
        return (rd != 0) && ((ID_use_rs && IFID_rs == rd) || (ID_use_rt && IFID_rt == rd));
    endfunction

    function automatic bit load_use();
        return IDEXE_DMRd && IDEXE_RFWr && dep(IDEXE_rd);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_br[i] = 0; m_mdu[i] = 0; m_ms[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_eval(input int i);
        e_to[i] = 0;
        if (m_br[i] > 0) begin
            e_stall[i] = 1;
        end else if (m_mdu[i]) begin
            if (!mdu_busy) e_stall[i] = 0;
            else if (m_ms[i] >= tmo[i]) begin
                e_stall[i] = 0;
                e_to[i] = 1;
            end else e_stall[i] = 1;
        end else begin
            e_stall[i] = (ID_mdu && mdu_busy) || load_use()
                       || (ID_branch && EXEMEM_DMRd && dep(EXEMEM_rd));
        end
    endtask

    task automatic model_commit(input int i);
        if (m_br[i] > 0) begin
            m_br[i]--;
        end else if (m_mdu[i]) begin
            if (e_stall[i]) m_ms[i]++;
            else m_mdu[i] = 0;
        end else if (ID_mdu && mdu_busy) begin
            m_mdu[i] = 1;
            m_ms[i] = 1;
        end else if (ID_branch && load_use()) begin
            m_br[i] = 1;
        end
        if (e_to[i]) m_err[i] = 1;
        if (e_stall[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        #2;
        checks++;
        if (ctl_a !== CTL_RUN || ctl_b !== CTL_RUN) begin
            errors++;
            $display("FAIL reset_ctl a=%b b=%b want %b", ctl_a, ctl_b, CTL_RUN);
        end
        checks++;
        if (a_cnt !== 32'd0 || b_cnt !== 4'd0 || a_err !== 1'b0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs cnt=%0d/%0d err=%b/%b want 0", a_cnt, b_cnt, a_err, b_err);
        end
        checks++;
        if (a_st !== HZ_IDLE || b_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL reset_state a=%0d b=%0d want IDLE", a_st, b_st);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        IDEXE_DMRd = 1; IDEXE_RFWr = 1; IDEXE_rd = 8; ID_use_rs = 1; IFID_rs = 8;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_STALL) begin
            errors++;
            $display("FAIL load_use_stall ctl=%b want %b", ctl_a, CTL_STALL);
        end
        next_cycle();
        IDEXE_DMRd = 0; IDEXE_RFWr = 0; IDEXE_rd = 0;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_RUN || a_cnt !== 32'd1 || a_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL load_use_release ctl=%b cnt=%0d st=%0d want %b 1 IDLE",
                     ctl_a, a_cnt, a_st, CTL_RUN);
        end
    endtask

    task automatic test_branch_ex();
        do_reset();
        ID_branch = 1; ID_use_rt = 1; IFID_rt = 9; br_taken = 1;
        IDEXE_DMRd = 1; IDEXE_RFWr = 1; IDEXE_rd = 9;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_STALL || a_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL br_ex_first ctl=%b st=%0d want %b IDLE", ctl_a, a_st, CTL_STALL);
        end
        next_cycle();
        IDEXE_DMRd = 0; IDEXE_RFWr = 0; IDEXE_rd = 0; EXEMEM_DMRd = 1; EXEMEM_rd = 9;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_STALL || a_st !== HZ_BR_HOLD) begin
            errors++;
            $display("FAIL br_ex_hold ctl=%b st=%0d want %b BR_HOLD", ctl_a, a_st, CTL_STALL);
        end
        next_cycle();
        EXEMEM_DMRd = 0; EXEMEM_rd = 0;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_TAKEN || a_cnt !== 32'd2) begin
            errors++;
            $display("FAIL br_ex_taken ctl=%b cnt=%0d want %b 2", ctl_a, a_cnt, CTL_TAKEN);
        end
        next_cycle();
        ID_branch = 0; br_taken = 0;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_RUN || a_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL br_ex_after ctl=%b st=%0d want %b IDLE", ctl_a, a_st, CTL_RUN);
        end
    endtask

    task automatic test_branch_mem();
        do_reset();
        ID_branch = 1; ID_use_rt = 1; IFID_rt = 9; EXEMEM_DMRd = 1; EXEMEM_rd = 9;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_STALL) begin
            errors++;
            $display("FAIL br_mem_stall ctl=%b want %b", ctl_a, CTL_STALL);
        end
        next_cycle();
        IFID_rt = 0; EXEMEM_rd = 0;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_RUN || a_cnt !== 32'd1 || a_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL br_mem_reg0 ctl=%b cnt=%0d st=%0d want %b 1 IDLE",
                     ctl_a, a_cnt, a_st, CTL_RUN);
        end
    endtask

    task automatic test_mdu_wait();
        int stalled;
        do_reset();
        ID_mdu = 1; mdu_busy = 1;
        stalled = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ctl_a === CTL_STALL) stalled++;
            next_cycle();
        end
        checks++;
        if (stalled != 5 || a_st !== HZ_MDU_WAIT) begin
            errors++;
            $display("FAIL mdu_wait_stalls got=%0d st=%0d want 5 MDU_WAIT", stalled, a_st);
        end
        mdu_busy = 0;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_RUN || a_err !== 1'b0 || a_cnt !== 32'd5) begin
            errors++;
            $display("FAIL mdu_wait_release ctl=%b err=%b cnt=%0d want %b 0 5",
                     ctl_a, a_err, a_cnt, CTL_RUN);
        end
        next_cycle();
        ID_mdu = 0;
        @(negedge clk);
        checks++;
        if (a_st !== HZ_IDLE || a_err !== 1'b0) begin
            errors++;
            $display("FAIL mdu_wait_idle st=%0d err=%b want IDLE 0", a_st, a_err);
        end
    endtask

    task automatic test_watchdog();
        int stalled;
        do_reset();
        ID_mdu = 1; mdu_busy = 1;
        stalled = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ctl_b === CTL_STALL) stalled++;
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (stalled != 4 || ctl_b !== CTL_RUN || b_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_release stalls=%0d ctl=%b err=%b want 4 %b 0",
                     stalled, ctl_b, b_err, CTL_RUN);
        end
        next_cycle();
        ID_mdu = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (b_err !== 1'b1 || b_st !== HZ_IDLE || b_cnt !== 4'd4 || ctl_b !== CTL_RUN) begin
            errors++;
            $display("FAIL wdog_sticky err=%b st=%0d cnt=%0d ctl=%b want 1 IDLE 4 %b",
                     b_err, b_st, b_cnt, ctl_b, CTL_RUN);
        end
        mdu_busy = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        IDEXE_DMRd = 1; IDEXE_RFWr = 1; IDEXE_rd = 3; ID_use_rt = 1; IFID_rt = 3;
        repeat (20) next_cycle();
        @(negedge clk);
        checks++;
        if (b_cnt !== 4'd15 || a_cnt !== 32'd20) begin
            errors++;
            $display("FAIL cnt_saturate narrow=%0d wide=%0d want 15 20", b_cnt, a_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ID_branch = 1; ID_use_rs = 1; IFID_rs = 5; IDEXE_DMRd = 1; IDEXE_RFWr = 1; IDEXE_rd = 5;
        next_cycle();
        IDEXE_DMRd = 0; IDEXE_RFWr = 0; IDEXE_rd = 0; EXEMEM_DMRd = 1; EXEMEM_rd = 5;
        #1;
        checks++;
        if (a_st !== HZ_BR_HOLD || ctl_a !== CTL_STALL) begin
            errors++;
            $display("FAIL rst_mid_pre st=%0d ctl=%b want BR_HOLD %b", a_st, ctl_a, CTL_STALL);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (ctl_a !== CTL_RUN || a_cnt !== 32'd0 || a_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL rst_mid ctl=%b cnt=%0d st=%0d want %b 0 IDLE", ctl_a, a_cnt, a_st, CTL_RUN);
        end
        clear_inputs();
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl_a !== CTL_RUN || a_st !== HZ_IDLE) begin
            errors++;
            $display("FAIL rst_mid_after ctl=%b st=%0d want %b IDLE", ctl_a, a_st, CTL_RUN);
        end
    endtask

    task automatic test_random();
        logic [4:0]  exp_ctl [2];
        logic [31:0] got_cnt [2];
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            IFID_rs     = 5'($urandom_range(0, 3));
            IFID_rt     = 5'($urandom_range(0, 3));
            IDEXE_rd    = 5'($urandom_range(0, 3));
            EXEMEM_rd   = 5'($urandom_range(0, 3));
            ID_use_rs   = 1'($urandom_range(0, 1));
            ID_use_rt   = 1'($urandom_range(0, 1));
            ID_branch   = ($urandom_range(0, 3) == 0);
            ID_mdu      = ($urandom_range(0, 3) == 0);
            br_taken    = 1'($urandom_range(0, 1));
            IDEXE_RFWr  = ($urandom_range(0, 3) != 0);
            IDEXE_DMRd  = ($urandom_range(0, 2) == 0);
            EXEMEM_DMRd = ($urandom_range(0, 2) == 0);
            mdu_busy    = ($urandom_range(0, 9) < 8);
            @(negedge clk);
            got_cnt[0] = a_cnt;
            got_cnt[1] = {28'd0, b_cnt};
            for (int i = 0; i < 2; i++) begin
                model_eval(i);
                exp_ctl[i] = e_stall[i] ? CTL_STALL : {2'b11, br_taken, 2'b00};
            end
            checks++;
            if (ctl_a !== exp_ctl[0] || ctl_b !== exp_ctl[1]) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d a=%b b=%b want %b %b",
                         n, ctl_a, ctl_b, exp_ctl[0], exp_ctl[1]);
            end
            checks++;
            if (longint'(got_cnt[0]) != m_cnt[0] || longint'(got_cnt[1]) != m_cnt[1]
                || a_err !== m_err[0] || b_err !== m_err[1]) begin
                errors++;
                $display("FAIL rand_regs cyc=%0d cnt=%0d/%0d err=%b/%b want %0d/%0d %b/%b",
                         n, got_cnt[0], got_cnt[1], a_err, b_err,
                         m_cnt[0], m_cnt[1], m_err[0], m_err[1]);
            end
            for (int i = 0; i < 2; i++) model_commit(i);
            next_cycle();
        end
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_ex();
        test_branch_mem();
        test_mdu_wait();
        test_watchdog();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
